// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: a control and data bundle behind a valid/ready handshake,
// with flush (bubble insertion) and an optional skid entry that lets In_Ready come from a flop.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DATA_W = 101,
  parameter int unsigned SKID   = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Flush,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [CTRL_W-1:0] In_Ctrl,
  input  logic [DATA_W-1:0] In_Data,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [CTRL_W-1:0] Out_Ctrl,
  output logic [DATA_W-1:0] Out_Data,
  output logic [1:0]        Occupancy
);

  logic              main_v_q, main_v_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_v_q, skid_v_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic              push, pop;

  assign push = In_Valid & In_Ready;
  assign pop  = main_v_q & Out_Ready;

  always_comb begin
    main_v_d    = main_v_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_v_d    = skid_v_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (Flush) begin
      // Data is left in place so Out_Data never goes X; only valid and ctrl are cleared.
      main_v_d    = 1'b0;
      main_ctrl_d = '0;
      skid_v_d    = 1'b0;
      skid_ctrl_d = '0;
    end else if (!main_v_q) begin
      if (push) begin
        main_v_d    = 1'b1;
        main_ctrl_d = In_Ctrl;
        main_data_d = In_Data;
      end
    end else if (skid_v_q) begin
      if (pop) begin
        main_ctrl_d = skid_ctrl_q;
        main_data_d = skid_data_q;
        skid_v_d    = 1'b0;
        skid_ctrl_d = '0;
      end
    end else begin
      if (push && pop) begin
        main_ctrl_d = In_Ctrl;
        main_data_d = In_Data;
      end else if (push && (SKID != 0)) begin
        skid_v_d    = 1'b1;
        skid_ctrl_d = In_Ctrl;
        skid_data_d = In_Data;
      end else if (pop) begin
        main_v_d    = 1'b0;
        main_ctrl_d = '0;
      end
    end
    in_ready_d = !(main_v_d & skid_v_d);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      main_v_q    <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_v_q    <= 1'b0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      main_v_q    <= main_v_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_v_q    <= skid_v_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Without a skid entry the stage can only accept when the head is leaving or absent.
  assign In_Ready  = (SKID != 0) ? in_ready_q : (!main_v_q | Out_Ready);
  assign Out_Valid = main_v_q;
  assign Out_Ctrl  = main_v_q ? main_ctrl_q : '0;
  assign Out_Data  = main_data_q;
  assign Occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Drives a SKID=0 and a SKID=1 stage with identical stimulus; each has its own scoreboard queue
// whose contents and capacity rules predict every output.
module tb_pipe_stage_reg;

  localparam int CW = 8;
  localparam int DW = 101;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic          Clock = 1'b0;
  logic          Reset, Flush, In_Valid, Out_Ready;
  logic [CW-1:0] In_Ctrl;
  logic [DW-1:0] In_Data;
  logic          in_ready  [2];
  logic          out_valid [2];
  logic [CW-1:0] out_ctrl  [2];
  logic [DW-1:0] out_data  [2];
  logic [1:0]    occ       [2];

  int   vectors = 0;
  int   miscompares = 0;
  bit   active = 1'b0;
  bit   rdy1_m = 1'b0;
  ent_t sbq [2][$];

  always #5 Clock = ~Clock;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) u_skid0 (
    .Clock(Clock), .Reset(Reset), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(in_ready[0]), .In_Ctrl(In_Ctrl), .In_Data(In_Data),
    .Out_Valid(out_valid[0]), .Out_Ready(Out_Ready), .Out_Ctrl(out_ctrl[0]),
    .Out_Data(out_data[0]), .Occupancy(occ[0])
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) u_skid1 (
    .Clock(Clock), .Reset(Reset), .Flush(Flush),
    .In_Valid(In_Valid), .In_Ready(in_ready[1]), .In_Ctrl(In_Ctrl), .In_Data(In_Data),
    .Out_Valid(out_valid[1]), .Out_Ready(Out_Ready), .Out_Ctrl(out_ctrl[1]),
    .Out_Data(out_data[1]), .Occupancy(occ[1])
  );

  task automatic check(input string name, input int k, input logic [127:0] got,
                       input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, k, $time, got, exp);
    end
  endtask

  // Monitor and scoreboard: compare outputs mid-cycle, then apply this cycle's edge to the model.
  always @(negedge Clock) begin
    int   n;
    bit   exp_v, exp_rdy;
    ent_t head;
    if (active) begin
      for (int k = 0; k < 2; k++) begin
        n       = sbq[k].size();
        exp_v   = (n > 0);
        exp_rdy = (k == 1) ? rdy1_m : ((n == 0) || Out_Ready);
        head    = exp_v ? sbq[k][0] : '0;
        check("out_valid", k, out_valid[k], exp_v);
        check("occupancy", k, occ[k], n);
        check("in_ready", k, in_ready[k], exp_rdy);
        check("out_ctrl", k, out_ctrl[k], head.c);
        if (exp_v) check("out_data", k, out_data[k], head.d);
        else       check("out_data_known", k, $isunknown(out_data[k]), 0);

        if (Reset) begin
          sbq[k].delete();
          if (k == 1) rdy1_m = 1'b0;
        end else if (Flush) begin
          sbq[k].delete();
          if (k == 1) rdy1_m = 1'b1;
        end else begin
          if (exp_v && Out_Ready) void'(sbq[k].pop_front());
          if (In_Valid && exp_rdy) sbq[k].push_back('{c: In_Ctrl, d: In_Data});
          if (k == 1) rdy1_m = (sbq[k].size() < 2);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic drive(input bit v, input logic [CW-1:0] c, input logic [DW-1:0] d);
    In_Valid = v;
    In_Ctrl  = c;
    In_Data  = d;
  endtask

  initial begin
    logic [127:0] r;
    bit           acc;
    Reset = 1'b1; Flush = 1'b0; Out_Ready = 1'b0;
    drive(1'b1, 8'hFF, '1);
    cyc();
    active = 1'b1;
    cyc();
    for (int k = 0; k < 2; k++) begin
      check("reset_data", k, out_data[k], 0);
      check("reset_ctrl", k, out_ctrl[k], 0);
    end
    Reset = 1'b0;
    drive(1'b0, '0, '0);
    cyc();
    check("in_ready_after_reset", 1, in_ready[1], 1);

    // Streaming, one entry per cycle.
    Out_Ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, CW'(i), DW'(i));
      cyc();
    end
    drive(1'b0, '0, '0);
    repeat (3) cyc();

    // Skid fill: A, B, C against a stalled output, then release.
    Out_Ready = 1'b0;
    drive(1'b1, 8'h0A, DW'('hA));
    cyc();
    drive(1'b1, 8'h0B, DW'('hB));
    cyc();
    drive(1'b1, 8'h0C, DW'('hC));
    repeat (2) cyc();
    Out_Ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      acc = in_ready[1];
      cyc();
      if (acc) break;
    end
    drive(1'b0, '0, '0);
    repeat (4) cyc();

    // Flush while full, with a push in the same cycle.
    Out_Ready = 1'b0;
    drive(1'b1, 8'h11, DW'('h11));
    cyc();
    drive(1'b1, 8'h22, DW'('h22));
    cyc();
    drive(1'b1, 8'hEE, DW'('hEE));
    Flush = 1'b1;
    cyc();
    Flush = 1'b0;
    drive(1'b0, '0, '0);
    Out_Ready = 1'b1;
    repeat (2) cyc();

    // Simultaneous push and pop at one entry.
    Out_Ready = 1'b0;
    drive(1'b1, 8'h58, DW'('h58));
    cyc();
    drive(1'b1, 8'h59, DW'('h59));
    Out_Ready = 1'b1;
    cyc();
    drive(1'b0, '0, '0);
    repeat (3) cyc();

    // Random traffic.
    for (int i = 0; i < 10000; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      drive(1'($urandom_range(0, 1)), CW'($urandom), r[DW-1:0]);
      Out_Ready = ($urandom_range(0, 99) < 60);
      Flush     = ($urandom_range(0, 99) < 5);
      cyc();
    end
    drive(1'b0, '0, '0);
    Flush = 1'b0;
    Out_Ready = 1'b1;
    repeat (4) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline stage register. It replaces the fixed-field, WriteEnable-gated inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block. Each instance carries a control bundle and a data bundle through a valid/ready handshake, supports flush (bubble insertion), and optionally contains a skid entry so In_Ready is driven from a flop. Instances sit between adjacent pipeline stages of the core.

## Interface
- CTRL_W, 8: width of control bundle (MemRead, MemWrite, RegWrite, ByteSel, ...); every control bit is zero in a bubble.
- DATA_W, 101: width of data bundle (ALU result, store data, PC+4, RegDest, ...).
- SKID, 1: 1 = two-entry skid buffer with registered In_Ready; 0 = single entry with combinational In_Ready.
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high; clock Clock.
- Flush  in  1  discard all held entries and any same-cycle input.
- In_Valid  in  1  upstream has a valid entry.
- In_Ready  out  1  stage accepts an entry this cycle.
- In_Ctrl  in  CTRL_W  upstream control bundle.
- In_Data  in  DATA_W  upstream data bundle.
- Out_Valid  out  1  head entry valid.
- Out_Ready  in  1  downstream accepts the head this cycle.
- Out_Ctrl  out  CTRL_W  head control; forced to all-zero whenever Out_Valid=0.
- Out_Data  out  DATA_W  head data; don't-care when Out_Valid=0, but holds its last value (no X).
- Occupancy  out  2  number of held entries: 0, 1, or 2 (2 only when SKID=1).

## Operation
- Push = In_Valid & In_Ready. Pop = Out_Valid & Out_Ready. Both are evaluated on the same edge.
- Storage: a main entry (head) and, when SKID=1, a skid entry. Each entry holds a valid bit, ctrl, and data.
- SKID=1 In_Ready is a flop equal to (Occupancy<2); it does not depend on Out_Ready.
- SKID=0 In_Ready = !Out_Valid | Out_Ready, which is combinational.
- Entry movement, in priority order:
  - Empty + push: entry goes to main.
  - Main only + push + pop: new entry replaces main.
  - Main only + push, no pop (SKID=1): entry goes to skid; Occupancy becomes 2.
  - Full + pop: skid moves to main. No push is possible, since In_Ready=0.
  - Pop without push: the popped entry leaves; Occupancy decrements.
- Ordering is strictly FIFO. No entry is duplicated or dropped, except by Flush.
- Flush has priority over push/pop:
  - Clears both valid bits and zeroes the stored ctrl of both entries.
  - A push presented in the same cycle is discarded.
  - Next cycle: Occupancy=0, Out_Valid=0, In_Ready=1.
- Reset has priority over Flush. All stored valid, ctrl, and data bits become 0.
- Legacy stall mapping: a stage that previously deasserted WriteEnable now deasserts Out_Ready downstream. Holding In_Valid at 1 with constant inputs reproduces the old behaviour.

## Timing
- Latency: 1 cycle from push edge to Out_Valid=1 when empty.
- Throughput: 1 entry/cycle sustained when Out_Ready=1, for both SKID values.
- Reset values:
  - Out_Valid=0, Out_Ctrl=0, Out_Data=0, Occupancy=0.
  - In_Ready=0 during Reset, then 1 on the first cycle after Reset deasserts.
  - With SKID=0, In_Ready=1 during Reset (combinational); pushes are ignored while Reset=1.
- Out_Ready may toggle every cycle. Out_Valid, once asserted, stays high with stable Out_Ctrl/Out_Data until popped or flushed.
- Reset or Flush mid-transfer (Occupancy=2): both entries are lost. The upstream holder of a blocked entry must re-present it; the stage does not replay it.
- Backpressure propagation with SKID=1: at most one cycle, because the skid entry absorbs the in-flight push.

## Test plan
- Reset: assert Reset 2 cycles with In_Valid=1, In_Ctrl=8'hFF -> Out_Valid=0, Out_Ctrl=0, Occupancy=0. One cycle after release, In_Ready=1.
- Streaming: push D=1..8 on consecutive cycles, Out_Ready=1 -> Out_Data=1..8 on consecutive cycles, 1-cycle latency, no bubbles, for SKID=0 and SKID=1.
- Skid fill (SKID=1): push A, B, C with Out_Ready=0 ->
  - A is head; B is in skid; Occupancy=2; In_Ready=0 while C waits.
  - Raise Out_Ready -> output order A, B, C, and C is accepted the cycle after A pops.
- Flush with push: Occupancy=2, In_Valid=1, Flush=1 -> next cycle Out_Valid=0, Out_Ctrl=0, Occupancy=0, and the pushed entry never appears at the output.
- Simultaneous push/pop at Occupancy=1: head=X, push Y, Out_Ready=1 -> next cycle head=Y, Occupancy=1.
- Random: random In_Valid/Out_Ready/Flush (5%) for 10k cycles against a scoreboard queue -> exact in-order match, Out_Ctrl=0 whenever Out_Valid=0, and Out_Valid entries stable while stalled.
